// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite slave-side signal bundle as seen behind the decoder and bus mux.
interface ahbl_sram_slave_if #(
  parameter int DW = 32
);
  logic          HSELx;
  logic [31:0]   HADDR;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;
  logic          HMASTLOCK;
  logic          HREADY;
  logic [DW-1:0] HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [DW-1:0] HRDATA;

  modport master (
    output HSELx, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSELx, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave fronting a word-organised SRAM with byte-lane writes,
// a fixed number of data-phase wait states and a two-cycle ERROR response.
module ahbl_sram_slave #(
  parameter int DW          = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahbl_sram_slave_if.slave bus
);
  localparam int BYTES = DW / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic [IDXW-1:0]  idx_q;
  logic [OFFW-1:0]  off_q;
  logic [2:0]       size_q;
  logic             write_q;
  logic             ready, resp;
  logic             accept, take, legal;
  logic [BYTES-1:0] lanes;
  logic [DW-1:0]    mem [DEPTH_WORDS];
  logic             unused_ok;

  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  assign accept = bus.HSELx & bus.HREADY & bus.HTRANS[1];
  assign take   = accept & ready;

  // Legality is judged on the full address so out-of-range indices never wrap.
  always_comb begin
    legal = 1'b1;
    if (bus.HSIZE > 3'(OFFW))
      legal = 1'b0;
    if ((bus.HADDR & ((32'd1 << bus.HSIZE) - 32'd1)) != 32'd0)
      legal = 1'b0;
    if ((bus.HADDR >> OFFW) >= 32'(DEPTH_WORDS))
      legal = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b1;
    resp      = 1'b0;
    case (state)
      S_WAIT: begin
        ready = 1'b0;
        if (cnt == 3'd0)
          state_nxt = S_DATA;
        else
          cnt_nxt = cnt - 3'd1;
      end
      S_ERR1: begin
        ready     = 1'b0;
        resp      = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: resp = 1'b1;
      default: ;
    endcase
    // IDLE, DATA and ERR2 all present HREADYOUT=1 and so may take a new address phase.
    if (ready) begin
      state_nxt = S_IDLE;
      if (accept) begin
        if (!legal) begin
          state_nxt = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 3'(WAIT_STATES - 1);
        end else begin
          state_nxt = S_DATA;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        idx_q   <= bus.HADDR[OFFW +: IDXW];
        off_q   <= bus.HADDR[OFFW-1:0];
        size_q  <= bus.HSIZE;
        write_q <= bus.HWRITE;
      end
    end
  end

  // An aligned transfer covers exactly the lanes sharing its size-aligned block.
  always_comb begin
    lanes = '0;
    for (int b = 0; b < BYTES; b++)
      if ((b >> size_q) == (int'(off_q) >> size_q))
        lanes[b] = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_q)
      for (int b = 0; b < BYTES; b++)
        if (lanes[b])
          mem[idx_q][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    = (state == S_DATA && !write_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Two-slave AHB-Lite system (zero-wait and three-wait SRAM) driven by a pipelined
// master, with a per-slave scoreboard fed from a word-array reference model.
module tb_ahbl_sram_slave;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  typedef struct {
    int          tgt;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          fixed;
    logic [31:0] fixed_rdata;
    bit          nomodel;
  } stim_t;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel0, hsel1, hwrite, hmastlock;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready_bus;
  int          cur_tgt = 2;
  int          dsel = 2;

  int          nchecks = 0;
  int          nfail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][64];
  bit          pend [2];
  exp_t        cur [2];
  int          wcnt [2];

  ahbl_sram_slave_if #(.DW(32)) bus0 ();
  ahbl_sram_slave_if #(.DW(32)) bus1 ();

  ahbl_sram_slave #(.DW(32), .DEPTH_WORDS(1024), .WAIT_STATES(WS0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0.slave));
  ahbl_sram_slave #(.DW(32), .DEPTH_WORDS(1024), .WAIT_STATES(WS1)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1.slave));

  assign bus0.HSELx = hsel0;       assign bus1.HSELx = hsel1;
  assign bus0.HADDR = haddr;       assign bus1.HADDR = haddr;
  assign bus0.HWRITE = hwrite;     assign bus1.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;       assign bus1.HSIZE = hsize;
  assign bus0.HBURST = hburst;     assign bus1.HBURST = hburst;
  assign bus0.HPROT = hprot;       assign bus1.HPROT = hprot;
  assign bus0.HTRANS = htrans;     assign bus1.HTRANS = htrans;
  assign bus0.HMASTLOCK = hmastlock; assign bus1.HMASTLOCK = hmastlock;
  assign bus0.HREADY = hready_bus; assign bus1.HREADY = hready_bus;
  assign bus0.HWDATA = hwdata;     assign bus1.HWDATA = hwdata;

  // Bus mux: the data-phase owner's HREADYOUT becomes the shared HREADY.
  assign hready_bus = (dsel == 0) ? bus0.HREADYOUT : (dsel == 1) ? bus1.HREADYOUT : 1'b1;

  always @(posedge HCLK)
    if (hready_bus) dsel <= cur_tgt;

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, k, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] size, input logic [31:0] addr);
    if (size > 3'd2) return 1'b0;
    if (addr % (32'd1 << size) != 32'd0) return 1'b0;
    if (addr / 4 >= 32'd1024) return 1'b0;
    return 1'b1;
  endfunction

  function automatic stim_t mk(input int tgt, input logic [1:0] trans, input bit write,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
    stim_t s;
    s.tgt = tgt; s.trans = trans; s.write = write; s.size = size;
    s.addr = addr; s.wdata = wdata; s.fixed = 1'b0; s.fixed_rdata = 32'd0; s.nomodel = 1'b0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    r;
    s = mk(0, 2'b10, 1'b0, 3'd2, 32'd0, $urandom);
    r = int'($urandom_range(0, 99));
    s.tgt = (r < 45) ? 0 : (r < 90) ? 1 : 2;
    r = int'($urandom_range(0, 9));
    s.trans = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
    s.write = bit'($urandom_range(0, 1));
    r = int'($urandom_range(0, 19));
    s.size = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    r = int'($urandom_range(0, 19));
    if (r == 0)
      s.addr = (32'h1000 + 32'($urandom_range(0, 32'h7FFF0000))) & 32'hFFFF_FFFC;
    else if (r == 1)
      s.addr = 32'($urandom_range(0, 255));
    else
      s.addr = 32'($urandom_range(0, 255)) & ~((32'd1 << s.size) - 32'd1);
    return s;
  endfunction

  // Drives one address phase, records the expected response, and returns just after
  // the edge that moves it into its data phase (with HWDATA then driven for it).
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   hr;
    int   guard;
    int   word;
    int   lane;
    hsel0 = (s.tgt == 0); hsel1 = (s.tgt == 1); cur_tgt = s.tgt;
    haddr = s.addr; hwrite = s.write; hsize = s.size; htrans = s.trans;
    hburst = 3'($urandom_range(0, 7)); hprot = 4'($urandom_range(0, 15));
    hmastlock = 1'($urandom_range(0, 1));
    if (s.tgt < 2 && s.trans[1]) begin
      e.err = !is_legal(s.size, s.addr);
      e.rd = !s.write;
      e.rdata = 32'd0;
      e.waits = e.err ? 1 : ((s.tgt == 1) ? WS1 : WS0);
      if (!e.err) begin
        word = int'(s.addr / 4);
        if (s.write) begin
          if (!s.nomodel)
            for (int b = 0; b < (1 << s.size); b++) begin
              lane = int'(s.addr % 4) + b;
              model[s.tgt][word][lane*8 +: 8] = s.wdata[lane*8 +: 8];
            end
        end else begin
          e.rdata = s.fixed ? s.fixed_rdata : model[s.tgt][word];
        end
      end
      if (s.tgt == 0) q0.push_back(e); else q1.push_back(e);
    end
    guard = 0;
    do begin
      @(negedge HCLK);
      hr = hready_bus;
      @(posedge HCLK);
      #1;
      guard++;
    end while (!hr && guard < 20);
    if (!hr) begin
      nchecks++; nfail++;
      $display("[TB] FAIL addr_phase_timeout dut%0d: got HREADY 0 expected 1 within 20 cycles", s.tgt);
    end
    hwdata = s.wdata;
  endtask

  // Monitor: checks each slave's outputs every cycle against its pending data phase.
  always @(negedge HCLK) begin
    for (int k = 0; k < 2; k++) begin
      logic        r, p, sel;
      logic [31:0] d;
      exp_t        nx;
      r   = (k == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
      p   = (k == 0) ? bus0.HRESP : bus1.HRESP;
      d   = (k == 0) ? bus0.HRDATA : bus1.HRDATA;
      sel = (k == 0) ? hsel0 : hsel1;
      if (!HRESETn) begin
        checkOutput("reset_hreadyout", k, 32'(r), 32'd1);
        checkOutput("reset_hresp", k, 32'(p), 32'd0);
        checkOutput("reset_hrdata", k, d, 32'd0);
        pend[k] = 1'b0;
      end else begin
        if (pend[k]) begin
          if (!r) begin
            wcnt[k]++;
            checkOutput("wait_hresp", k, 32'(p), 32'(cur[k].err));
            checkOutput("wait_hrdata", k, d, 32'd0);
            if (wcnt[k] > 10) begin
              nchecks++; nfail++;
              $display("[TB] FAIL stuck_wait dut%0d: got %0d wait cycles expected %0d", k, wcnt[k], cur[k].waits);
              pend[k] = 1'b0;
            end
          end else begin
            checkOutput("wait_count", k, 32'(wcnt[k]), 32'(cur[k].waits));
            checkOutput("done_hresp", k, 32'(p), 32'(cur[k].err));
            if (cur[k].rd)
              checkOutput("read_hrdata", k, d, cur[k].err ? 32'd0 : cur[k].rdata);
          end
        end else begin
          checkOutput("idle_hreadyout", k, 32'(r), 32'd1);
          checkOutput("idle_hresp", k, 32'(p), 32'd0);
          checkOutput("idle_hrdata", k, d, 32'd0);
        end
        if (hready_bus) begin
          pend[k] = 1'b0;
          if (sel && htrans[1]) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
              nchecks++; nfail++;
              $display("[TB] FAIL unexpected_accept dut%0d: got accept expected none", k);
            end else begin
              nx = (k == 0) ? q0.pop_front() : q1.pop_front();
              cur[k] = nx; pend[k] = 1'b1; wcnt[k] = 0;
            end
          end
        end
      end
    end
  end

  task automatic resetMidTransfer();
    stim_t s;
    s = mk(1, 2'b10, 1'b1, 3'd2, 32'h80, 32'hCAFEF00D);
    s.nomodel = 1'b1;
    applyStimulus(s);
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; cur_tgt = 2;
    @(posedge HCLK);
    #3;
    checkOutput("reset_test_in_wait", 1, 32'(bus1.HREADYOUT), 32'd0);
    HRESETn = 1'b0;
    #1;
    checkOutput("async_reset_hreadyout", 1, 32'(bus1.HREADYOUT), 32'd1);
    checkOutput("async_reset_hresp", 1, 32'(bus1.HRESP), 32'd0);
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    applyStimulus(mk(1, 2'b10, 1'b0, 3'd2, 32'h80, 32'd0));
  endtask

  initial begin
    stim_t s;
    HRESETn = 1'b0;
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'd0;
    repeat (3) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    for (int t = 0; t < 2; t++)
      for (int w = 0; w < 64; w++)
        applyStimulus(mk(t, 2'b10, 1'b1, 3'd2, 32'(w * 4), $urandom));

    applyStimulus(mk(0, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
    s = mk(0, 2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    s.fixed = 1'b1; s.fixed_rdata = 32'hDEADBEEF;
    applyStimulus(s);

    applyStimulus(mk(0, 2'b10, 1'b1, 3'd2, 32'h20, 32'h0000_0000));
    applyStimulus(mk(0, 2'b10, 1'b1, 3'd0, 32'h21, 32'h0000_AA00));
    applyStimulus(mk(0, 2'b11, 1'b1, 3'd1, 32'h22, 32'h5566_0000));
    s = mk(0, 2'b10, 1'b0, 3'd2, 32'h20, 32'd0);
    s.fixed = 1'b1; s.fixed_rdata = 32'h5566_AA00;
    applyStimulus(s);

    applyStimulus(mk(1, 2'b10, 1'b0, 3'd2, 32'h40, 32'd0));
    applyStimulus(mk(2, 2'b00, 1'b0, 3'd2, 32'h0, 32'd0));

    for (int t = 0; t < 2; t++) begin
      applyStimulus(mk(t, 2'b10, 1'b1, 3'd2, 32'h02, 32'h1234_5678));
      applyStimulus(mk(t, 2'b10, 1'b0, 3'd2, 32'h1000, 32'd0));
      applyStimulus(mk(t, 2'b10, 1'b0, 3'd2, 32'h00, 32'd0));
    end

    applyStimulus(mk(0, 2'b01, 1'b1, 3'd2, 32'h10, 32'hFFFF_FFFF));
    applyStimulus(mk(2, 2'b10, 1'b1, 3'd2, 32'h10, 32'h0BAD_F00D));
    s = mk(0, 2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    s.fixed = 1'b1; s.fixed_rdata = 32'hDEADBEEF;
    applyStimulus(s);

    for (int i = 0; i < 400; i++)
      applyStimulus(rand_stim());

    applyStimulus(mk(2, 2'b00, 1'b0, 3'd2, 32'h0, 32'd0));
    resetMidTransfer();

    applyStimulus(mk(2, 2'b00, 1'b0, 3'd2, 32'h0, 32'd0));
    applyStimulus(mk(2, 2'b00, 1'b0, 3'd2, 32'h0, 32'd0));
    repeat (3) @(negedge HCLK);
    checkOutput("queue_drained", 0, 32'(q0.size()), 32'd0);
    checkOutput("queue_drained", 1, 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end
endmodule

// File: doc/ahbl_sram_slave.md
Name: ahbl_sram_slave

Overview:
- AHB-Lite slave endpoint that sits directly behind the address decoder and bus mux; it consumes the slave-side signal bundle (HSELx, address/control, HWDATA) and produces HREADYOUT/HRESP/HRDATA.
- Backs an on-chip word-organised SRAM array with byte-lane writes, a programmable number of wait states, and a two-cycle ERROR response for illegal accesses.
- Serves as the standard memory target for SoC integration and as the reference slave for bus-level verification.

Parameters:
- DW, 32, data bus width in bits (32 or 64).
- DEPTH_WORDS, 1024, number of DW-bit words in the array (power of two).
- WAIT_STATES, 0, data-phase wait cycles inserted per accepted transfer (0..7).

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSELx  in  1  slave select from the decoder.
- HADDR  in  32  byte address; the word index is taken from the low bits above the byte offset.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size as log2 of bytes.
- HBURST  in  3  burst type; accepted and ignored.
- HPROT  in  4  protection; accepted and ignored.
- HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HMASTLOCK  in  1  accepted and ignored.
- HREADY  in  1  bus-wide ready from the mux.
- HWDATA  in  DW  write data, valid during the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DW  read data.

Behaviour:
- Reset is asynchronous and active-low; the clock is HCLK and the reset is HRESETn.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Array contents are not reset.
- Address phase is accepted only on a rising edge where HSELx=1, HREADY=1 and HTRANS[1]=1. The block then registers addr, size and write.
- If HREADY=0, or HSELx=0, or HTRANS is IDLE or BUSY, no transfer is accepted. The next cycle is zero-wait OKAY with no side effect.
- A transfer is illegal if any of the following holds:
  - HSIZE > log2(DW/8);
  - HADDR is not aligned to 2^HSIZE;
  - the word index is >= DEPTH_WORDS, with the index computed from the full HADDR (no wrap-around).
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. On a legal accept, go to WAIT if WAIT_STATES>0, else DATA. On an illegal accept, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. The transfer completes this cycle. A new accept here is a back-to-back transfer and follows the IDLE rules; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept follows the IDLE rules; otherwise go to IDLE.
- Latency: a legal transfer completes WAIT_STATES+1 cycles after its address phase.
- Writes: HWDATA is sampled at the DATA edge. Only byte lanes selected by the captured size and the low address bits are written, little-endian. The other lanes are unchanged.
- Reads: in DATA, HRDATA carries the full word at the captured index; all lanes are driven regardless of size. HRDATA=0 in every other state.
- Read-after-write to the same word, back-to-back: the read returns the newly written bytes. The write commits at the edge that ends its DATA cycle, before the read's DATA cycle.
- An ERROR transfer never modifies the array.
- BUSY or IDLE issued during ERR2 cancels cleanly.
- Bursts are handled as independent beats; SEQ and NONSEQ are treated identically.
- If HRESETn asserts mid-transfer, all outputs return asynchronously to their reset values, any in-flight write is discarded, and the FSM goes to IDLE.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → read DATA cycle HRDATA=0xDEADBEEF, HREADYOUT=1 throughout, HRESP=0.
- Byte writes: write byte 0xAA to 0x21, then halfword 0x5566 to 0x22, over a word that held 0x00000000 → read 0x20 returns 0x556_6AA00.
- WAIT_STATES=3: read 0x40 → HREADYOUT=0 for exactly 3 cycles, then 1 with valid HRDATA; the next address phase is not sampled while HREADY=0.
- Illegal accesses: word write to 0x02 (misaligned), and read of 0x1000 with DEPTH_WORDS=1024 → each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). A subsequent read of 0x00 shows it unmodified.
- No-accept cases: HSELx=1 with HTRANS=BUSY, and HSELx=0 with HTRANS=NONSEQ → zero-wait OKAY, HRDATA=0, array unchanged.
- Reset mid-operation: with WAIT_STATES=3, assert HRESETn=0 during WAIT of a write to 0x80 → HREADYOUT=1 and HRESP=0 immediately. After release, a read of 0x80 returns the pre-write value.
